// File: rtl/alu_vec_pkg.sv
// Shared definitions for the ALU vector sequencer: sequencer states and the
// bit layout of the packed test vector and of the log record.
package alu_vec_pkg;

  localparam int NZVC_W = 4;
  localparam int N_BIT  = 3;
  localparam int Z_BIT  = 2;
  localparam int V_BIT  = 1;
  localparam int C_BIT  = 0;

  // Test vector, MSB first: {op, a, b, cin, exp_res, exp_nzvc}
  localparam int VEC_NZVC_OFF = 0;
  localparam int VEC_EXP_OFF  = NZVC_W;

  // Log record, MSB first: {index, res, nzvc, pass}
  localparam int LOG_PASS_OFF = 0;
  localparam int LOG_NZVC_OFF = 1;
  localparam int LOG_RES_OFF  = 1 + NZVC_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_LOG,
    ST_DONE
  } state_e;

  function automatic int vec_w(input int op_w, input int data_w);
    return op_w + 3 * data_w + 5;
  endfunction

  function automatic int vec_cin_off(input int data_w);
    return NZVC_W + data_w;
  endfunction

  function automatic int vec_b_off(input int data_w);
    return NZVC_W + data_w + 1;
  endfunction

  function automatic int vec_a_off(input int data_w);
    return NZVC_W + 2 * data_w + 1;
  endfunction

  function automatic int vec_op_off(input int data_w);
    return NZVC_W + 3 * data_w + 1;
  endfunction

  function automatic int log_idx_off(input int data_w);
    return LOG_RES_OFF + data_w;
  endfunction

endpackage

// File: rtl/alu_vec_ram.sv
// Vector table: one write port, one registered read port.
module alu_vec_ram
  import alu_vec_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 107,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the storage and read register carry no reset so this maps onto block RAM;
  // the table contents intentionally survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/alu_vector_sequencer.sv
// Issues stored ALU test vectors one at a time, checks each response and
// streams a per-vector log record over a valid/ready port.
module alu_vector_sequencer
  import alu_vec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int DEPTH   = 32,
  parameter int ALU_LAT = 1,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int VEC_W   = vec_w(OP_W, DATA_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_we,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [VEC_W-1:0]         ld_data,
  input  logic                     start,
  input  logic [ADDR_W:0]          num_vec,
  input  logic                     stop_on_fail,
  output logic [OP_W-1:0]          alu_op,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic                     alu_cin,
  input  logic [DATA_W-1:0]        alu_res,
  input  logic [NZVC_W-1:0]        alu_nzvc,
  output logic                     log_valid,
  input  logic                     log_ready,
  output logic [ADDR_W+DATA_W+4:0] log_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          fail_cnt,
  output logic [ADDR_W-1:0]        first_fail,
  output logic                     first_fail_vld
);

  localparam int LOG_W       = ADDR_W + DATA_W + 5;
  localparam int LAT_W       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int OFF_OP      = vec_op_off(DATA_W);
  localparam int OFF_A       = vec_a_off(DATA_W);
  localparam int OFF_B       = vec_b_off(DATA_W);
  localparam int OFF_CIN     = vec_cin_off(DATA_W);
  localparam int OFF_LOG_IDX = log_idx_off(DATA_W);

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);
  localparam logic [ADDR_W:0]  DEPTH_N  = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic                sof_q, sof_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [NZVC_W-1:0]   nzvc_q, nzvc_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                cin_q, cin_d;
  logic [LOG_W-1:0]    log_q, log_d;
  logic [ADDR_W:0]     fail_cnt_q, fail_cnt_d;
  logic [ADDR_W-1:0]   first_fail_q, first_fail_d;
  logic                ffv_q, ffv_d;
  logic                done_q, done_d;

  logic [VEC_W-1:0]    rd_data;
  logic                ram_we;
  logic                chk_pass;
  logic                last_vec;

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign ram_we   = ld_we && !busy;
  assign chk_pass = (res_q == rd_data[VEC_EXP_OFF +: DATA_W]) &&
                    (nzvc_q == rd_data[VEC_NZVC_OFF +: NZVC_W]);
  assign last_vec = ({1'b0, idx_q} + (ADDR_W + 1)'(1)) == num_q;

  // The read register holds the fetched vector until the next FETCH, so the
  // expected values are taken straight from it in CHECK.
  alu_vec_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (VEC_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (state_q == ST_FETCH),
    .raddr (idx_q),
    .rdata (rd_data)
  );

  // NOTE: every next-state variable is defaulted to its register first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    num_d        = num_q;
    sof_d        = sof_q;
    lat_d        = lat_q;
    res_d        = res_q;
    nzvc_d       = nzvc_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    log_d        = log_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    ffv_d        = ffv_q;
    done_d       = done_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_d        = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
          sof_d        = stop_on_fail;
          idx_d        = '0;
          fail_cnt_d   = '0;
          first_fail_d = '0;
          ffv_d        = 1'b0;
          if (num_vec == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
            done_d  = 1'b0;
          end
        end
      end
      ST_FETCH: state_d = ST_DRIVE;
      ST_DRIVE: begin
        op_d    = rd_data[OFF_OP +: OP_W];
        a_d     = rd_data[OFF_A +: DATA_W];
        b_d     = rd_data[OFF_B +: DATA_W];
        cin_d   = rd_data[OFF_CIN];
        lat_d   = LAT_LAST;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          res_d   = alu_res;
          nzvc_d  = alu_nzvc;
          state_d = ST_CHECK;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_CHECK: begin
        if (!chk_pass) begin
          if (fail_cnt_q != '1) begin
            fail_cnt_d = fail_cnt_q + (ADDR_W + 1)'(1);
          end
          if (!ffv_q) begin
            first_fail_d = idx_q;
            ffv_d        = 1'b1;
          end
        end
        log_d                              = '0;
        log_d[OFF_LOG_IDX +: ADDR_W]       = idx_q;
        log_d[LOG_RES_OFF +: DATA_W]       = res_q;
        log_d[LOG_NZVC_OFF +: NZVC_W]      = nzvc_q;
        log_d[LOG_PASS_OFF]                = chk_pass;
        state_d                            = ST_LOG;
      end
      ST_LOG: begin
        if (log_ready) begin
          if ((sof_q && !log_q[LOG_PASS_OFF]) || last_vec) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      num_q        <= '0;
      sof_q        <= 1'b0;
      lat_q        <= '0;
      res_q        <= '0;
      nzvc_q       <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      log_q        <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      ffv_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      num_q        <= num_d;
      sof_q        <= sof_d;
      lat_q        <= lat_d;
      res_q        <= res_d;
      nzvc_q       <= nzvc_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      log_q        <= log_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      ffv_q        <= ffv_d;
      done_q       <= done_d;
    end
  end

  assign alu_op         = op_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_cin        = cin_q;
  assign log_valid      = (state_q == ST_LOG);
  assign log_data       = log_q;
  assign done           = done_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail     = first_fail_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Bench for alu_vector_sequencer: golden ALU, a vector-level model of the
// expected log stream and status, and directed runs with literal pins.
module tb_alu_vector_sequencer;

  localparam int DW    = 32;
  localparam int OW    = 6;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int LW    = AW + DW + 5;

  typedef struct packed {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic [DW-1:0] exp_res;
    logic [3:0]    nzvc;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  vec_t          ld_data;
  logic          start;
  logic [AW:0]   num_vec;
  logic          stop_on_fail;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic          alu_cin;
  logic [3:0]    alu_nzvc;
  logic          log_valid, log_ready;
  logic [LW-1:0] log_data;
  logic          busy, done;
  logic [AW:0]   fail_cnt;
  logic [AW-1:0] first_fail;
  logic          first_fail_vld;

  always #5 clk = ~clk;

  alu_vector_sequencer #(
    .DATA_W (DW), .OP_W (OW), .DEPTH (DEPTH), .ALU_LAT (1)
  ) dut (
    .clk (clk), .reset (reset), .ld_we (ld_we), .ld_addr (ld_addr),
    .ld_data (ld_data), .start (start), .num_vec (num_vec),
    .stop_on_fail (stop_on_fail), .alu_op (alu_op), .alu_a (alu_a),
    .alu_b (alu_b), .alu_cin (alu_cin), .alu_res (alu_res),
    .alu_nzvc (alu_nzvc), .log_valid (log_valid), .log_ready (log_ready),
    .log_data (log_data), .busy (busy), .done (done), .fail_cnt (fail_cnt),
    .first_fail (first_fail), .first_fail_vld (first_fail_vld)
  );

  // Reference SPARC-style ALU returning {res, N, Z, V, C}.
  function automatic logic [35:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    logic [32:0] s;
    logic [31:0] r;
    logic        v, c;
    s = '0; r = '0; v = 1'b0; c = 1'b0;
    case (op)
      6'b000000, 6'b001000: begin
        s = {1'b0, a} + {1'b0, b} + ((op == 6'b001000) ? {32'b0, cin} : 33'b0);
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      6'b000100: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      6'b000001: r = a & b;
      6'b000010: r = a | b;
      6'b000011: r = a ^ b;
      default:   r = '0;
    endcase
    return {r, r[31], (r == 32'b0), v, c};
  endfunction

  always_comb {alu_res, alu_nzvc} = alu_ref(alu_op, alu_a, alu_b, alu_cin);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model state: table copy and the expected global log stream.
  vec_t          tbl [DEPTH];
  logic [LW-1:0] exp_arr [1024];
  int            exp_total = 0;
  int            plan_nrec, plan_fails, plan_ff;
  bit            plan_ffv;
  int            base_rec;

  // Monitor: checks every accepted record and record stability under stall.
  int            rec_cnt = 0;
  logic [LW-1:0] got_q [$];
  logic          stall_q = 1'b0;
  logic [LW-1:0] held_q;

  always @(negedge clk) begin
    if (reset) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("log_hold_valid", 128'(log_valid), 128'd1);
        check("log_hold_data", 128'(log_data), 128'(held_q));
      end
      if (log_valid && log_ready) begin
        if (rec_cnt < exp_total) check("log_rec", 128'(log_data), 128'(exp_arr[rec_cnt]));
        else                     check("log_extra", 128'(log_data), {128{1'b1}});
        got_q.push_back(log_data);
        rec_cnt <= rec_cnt + 1;
      end
      stall_q <= log_valid && !log_ready;
      held_q  <= log_data;
    end
  end

  task automatic plan_run(input int n, input bit sof);
    int          nn;
    logic [35:0] r;
    bit          pass;
    nn = (n > DEPTH) ? DEPTH : n;
    plan_nrec = 0; plan_fails = 0; plan_ff = 0; plan_ffv = 1'b0;
    for (int i = 0; i < nn; i++) begin
      r    = alu_ref(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin);
      pass = (r[35:4] == tbl[i].exp_res) && (r[3:0] == tbl[i].nzvc);
      exp_arr[exp_total] = {AW'(i), r, pass};
      exp_total++;
      plan_nrec++;
      if (!pass) begin
        plan_fails++;
        if (!plan_ffv) begin plan_ff = i; plan_ffv = 1'b1; end
        if (sof) break;
      end
    end
  endtask

  task automatic load(input int idx, input vec_t v);
    @(posedge clk); #1;
    ld_we = 1'b1; ld_addr = AW'(idx); ld_data = v;
    tbl[idx] = v;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic start_run(input int n, input bit sof);
    @(posedge clk); #1;
    base_rec = rec_cnt;
    start = 1'b1; num_vec = (AW + 1)'(n); stop_on_fail = sof;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int exp_cycles);
    int cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done"}, 128'(done), 128'd1);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_nrec"}, 128'(rec_cnt - base_rec), 128'(plan_nrec));
    check({tag, "_fail_cnt"}, 128'(fail_cnt), 128'(plan_fails));
    check({tag, "_ffv"}, 128'(first_fail_vld), 128'(plan_ffv));
    check({tag, "_ff"}, 128'(first_fail), 128'(plan_ff));
    if (exp_cycles >= 0) check({tag, "_cycles"}, 128'(cyc), 128'(exp_cycles));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_alu"}, 128'({alu_op, alu_a, alu_b, alu_cin}), 128'd0);
    check({tag, "_log"}, 128'({log_valid, log_data}), 128'd0);
    check({tag, "_status"}, 128'({busy, done, fail_cnt, first_fail, first_fail_vld}), 128'd0);
  endtask

  task automatic pin_case1(input string tag, input int base);
    logic [LW-1:0] l0, l1, l2;
    l0 = {5'd0, 32'd7, 4'b0000, 1'b1};
    l1 = {5'd1, 32'hFFFF_FFFD, 4'b1001, 1'b1};
    l2 = {5'd2, 32'd0, 4'b0100, 1'b1};
    check({tag, "_lit0"}, 128'(got_q[base]), 128'(l0));
    check({tag, "_lit1"}, 128'(got_q[base + 1]), 128'(l1));
    check({tag, "_lit2"}, 128'(got_q[base + 2]), 128'(l2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          v;
    logic [35:0]   r;
    logic [OW-1:0] op_sel;
    logic [LW-1:0] l0;

    reset = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
    num_vec = '0; stop_on_fail = 1'b0; log_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // Case 1: three passing vectors.
    load(0, '{op: 6'b000000, a: 32'd5, b: 32'd2, cin: 1'b0, exp_res: 32'd7, nzvc: 4'b0000});
    load(1, '{op: 6'b000100, a: 32'd2, b: 32'd5, cin: 1'b0, exp_res: 32'hFFFF_FFFD, nzvc: 4'b1001});
    load(2, '{op: 6'b000001, a: 32'd5, b: 32'd2, cin: 1'b0, exp_res: 32'd0, nzvc: 4'b0100});
    plan_run(3, 1'b0);
    start_run(3, 1'b0);
    finish_run("c1", 15);
    pin_case1("c1", base_rec);
    check("c1_fail_cnt_lit", 128'(fail_cnt), 128'd0);

    // Case 2: wrong expectation on v1.
    v = tbl[1]; v.exp_res = 32'hFFFF_FFFE; load(1, v);
    plan_run(3, 1'b0);
    start_run(3, 1'b0);
    finish_run("c2", 15);
    check("c2_rec1_pass_lit", 128'(got_q[base_rec + 1][0]), 128'd0);
    check("c2_ff_lit", 128'({fail_cnt, first_fail, first_fail_vld}), 128'({6'd1, 5'd1, 1'b1}));

    // Case 3: stop on first fail.
    plan_run(3, 1'b1);
    start_run(3, 1'b1);
    finish_run("c3", 10);
    check("c3_op_lit", 128'(alu_op), 128'(6'b000100));

    // Case 4: consumer stalls record 0 for 10 cycles.
    v = tbl[1]; v.exp_res = 32'hFFFF_FFFD; load(1, v);
    plan_run(3, 1'b0);
    log_ready = 1'b0;
    start_run(3, 1'b0);
    for (int i = 0; i < 100 && !log_valid; i++) begin
      @(posedge clk); #1;
    end
    check("c4_valid_seen", 128'(log_valid), 128'd1);
    l0 = {5'd0, 32'd7, 4'b0000, 1'b1};
    repeat (10) begin
      @(posedge clk); #1;
      check("c4_stall_data", 128'(log_data), 128'(l0));
      check("c4_stall_op", 128'(alu_op), 128'(6'b000000));
    end
    check("c4_stall_valid", 128'(log_valid), 128'd1);
    log_ready = 1'b1;
    finish_run("c4", -1);

    // Case 5: empty run, then an over-long run clamped to the table depth.
    plan_run(0, 1'b0);
    start_run(0, 1'b0);
    finish_run("c5_nv0", 0);
    for (int i = 3; i < DEPTH; i++) begin
      case (i % 5)
        0: op_sel = 6'b000000;
        1: op_sel = 6'b000100;
        2: op_sel = 6'b000001;
        3: op_sel = 6'b000010;
        default: op_sel = 6'b001000;
      endcase
      v.op  = op_sel;
      v.a   = (32'(i) * 32'h0101_0101) ^ ((i % 2 == 0) ? 32'h8000_0000 : 32'h0);
      v.b   = 32'(i * 7) ^ ((i % 3 == 0) ? 32'hF000_0000 : 32'h0);
      v.cin = i[0];
      r     = alu_ref(v.op, v.a, v.b, v.cin);
      v.exp_res = (i % 7 == 0) ? (r[35:4] ^ 32'd1) : r[35:4];
      v.nzvc    = r[3:0];
      load(i, v);
    end
    plan_run(40, 1'b0);
    start_run(40, 1'b0);
    finish_run("c5_nv40", 160);
    check("c5_fail_lit", 128'({fail_cnt, first_fail}), 128'({6'd4, 5'd7}));

    // Case 6: reset in the WAIT cycle of v1, then table writes while busy.
    plan_run(3, 1'b0);
    start_run(3, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero("c6_rst");
    check("c6_rst_nrec", 128'(rec_cnt - base_rec), 128'd1);
    reset = 1'b0;
    exp_total = rec_cnt;

    plan_run(3, 1'b0);
    start_run(3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ld_we = 1'b1; ld_addr = AW'(i % 3); ld_data = '1;
      @(posedge clk); #1;
    end
    ld_we = 1'b0;
    finish_run("c6_busywr", -1);
    pin_case1("c6_busywr", base_rec);

    plan_run(3, 1'b0);
    start_run(3, 1'b0);
    finish_run("c6_rerun", 15);
    pin_case1("c6_rerun", base_rec);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_vector_sequencer.md
Name: alu_vector_sequencer

Overview:
Synthesizable, parametrised successor to the file-driven ALU bench. It holds a loadable table of ALU test vectors (op, a, b, cin, expected result, expected NZVC) and issues them to an ALU instance one at a time. It compares each response against the expected values and streams a per-vector log record through a valid/ready port. It sits beside the alu core in the datapath test harness and counts mismatches; an optional stop-on-first-fail mode is provided.

Parameters:
DATA_W, 32, ALU operand/result width
OP_W, 6, opcode width (SPARC op3)
DEPTH, 32, vector table entries (power of two)
ALU_LAT, 1, cycles from operand drive to valid ALU outputs (>=1)
ADDR_W, $clog2(DEPTH), table index width (derived)
VEC_W, OP_W+3*DATA_W+5, packed vector width (derived)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ld_we  in  1  table write strobe
ld_addr  in  ADDR_W  table write index
ld_data  in  VEC_W  packed vector {op,a,b,cin,exp_res,exp_nzvc}, MSB first
start  in  1  begin a run (sampled in IDLE/DONE only)
num_vec  in  ADDR_W+1  vectors to run, sampled with start
stop_on_fail  in  1  sampled with start; 1 = halt after first mismatch
alu_op  out  OP_W  ALU opcode
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_cin  out  1  ALU carry in
alu_res  in  DATA_W  ALU result
alu_nzvc  in  4  ALU flags {N,Z,V,C}
log_valid  out  1  log record valid
log_ready  in  1  consumer accepts record
log_data  out  ADDR_W+DATA_W+5  {index,res,nzvc,pass}
busy  out  1  run in progress
done  out  1  run complete; held until next start
fail_cnt  out  ADDR_W+1  mismatch count, saturating
first_fail  out  ADDR_W  index of first mismatch
first_fail_vld  out  1  first_fail is valid

Behaviour:
- Reset (synchronous, active-high): state=IDLE; every output listed above = 0. Table RAM is not cleared.
- States: IDLE, FETCH, DRIVE, WAIT, CHECK, LOG, DONE.
- IDLE/DONE + start: latch num_vec (clamped to DEPTH) and stop_on_fail; idx=0; clear fail_cnt, first_fail, first_fail_vld, done.
  - num_vec==0: go to DONE, done=1 next cycle.
  - Otherwise: go to FETCH.
- FETCH (1 cycle): synchronous RAM read of idx.
- DRIVE (1 cycle): register op/a/b/cin onto alu_* outputs; alu_* outputs hold until the next DRIVE or reset.
- WAIT: ALU_LAT cycles; sample alu_res/alu_nzvc on the last WAIT edge.
- CHECK (1 cycle): pass = (res==exp_res) && (nzvc==exp_nzvc).
  - On fail: fail_cnt+1, saturating at all-ones. If first_fail_vld==0, set first_fail=idx and first_fail_vld=1.
  - Build log_data.
- LOG: log_valid=1. log_data is stable while log_valid && !log_ready. On handshake, log_valid drops next cycle, then:
  - to DONE if (stop_on_fail && !pass) or idx==num_vec-1;
  - else idx+1 and FETCH.
- Per-vector latency with log_ready=1: 4+ALU_LAT cycles. DONE: busy=0, done=1.
- busy=1 in all states other than IDLE/DONE.
- ld_we while busy is ignored. ld_we in IDLE/DONE writes the RAM in the same cycle.
- start while busy is ignored.
- Reset mid-run aborts immediately; no partial log record is emitted.

Decomposition:
- Package alu_vec_pkg: field offset/width localparams for ld_data and log_data, NZVC bit indices, state enum, VEC_W function.
- Sub-module alu_vec_ram: DEPTH x VEC_W, one write port, one synchronous read port, no reset.

Test Plan:
1. Golden alu, ALU_LAT=1. Load vectors:
   - v0: ADD (000000) 5+2 -> exp 7, nzvc 0000
   - v1: SUB (000100) 2-5 -> exp 0xFFFFFFFD, nzvc 1001
   - v2: AND (000001) 5&2 -> exp 0, nzvc 0100
   Run num_vec=3 -> 3 records with pass=1, fail_cnt=0, first_fail_vld=0, done at cycle 15 after start.
2. Same run with v1 expected set to 0xFFFFFFFE -> record 1 pass=0, fail_cnt=1, first_fail=1, records 0 and 2 still pass, 3 records total.
3. Case 2 with stop_on_fail=1 -> exactly 2 records, done=1, alu_op remains 000100.
4. log_ready low for 10 cycles on record 0 -> log_valid and log_data held constant, alu_op unchanged, run completes afterwards.
5. start with num_vec=0 -> done=1 next cycle, no log_valid. num_vec=40 with DEPTH=32 -> exactly 32 records.
6. reset pulsed during WAIT of v1 -> next cycle all outputs 0, state IDLE. ld_we during busy leaves the table unchanged (rerun matches case 1).
